multdiv_seq: RTL

// Parametrised iterative multiply/divide unit for the processor execute stage. Radix-4 Booth

---
 rtl/multdiv_pkg.sv | 32 +++
 rtl/multdiv_if.sv | 25 ++
 rtl/multdiv_addsub.sv | 18 +
 rtl/multdiv_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package multdiv_pkg;

    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_e;

    typedef enum logic {OP_MULT, OP_DIV} op_e;

    // Radix-4 Booth digit selected by {b[i+1], b[i], b[i-1]}
    typedef enum logic [2:0] {BoothZero, BoothP1, BoothP2, BoothM1, BoothM2} booth_e;

    function automatic booth_e booth_decode(input logic [2:0] bits);
        booth_e d;
        case (bits)
            3'b001, 3'b010: d = BoothP1;
            3'b011:         d = BoothP2;
            3'b100:         d = BoothM2;
            3'b101, 3'b110: d = BoothM1;
            default:        d = BoothZero;
        endcase
        return d;
    endfunction

    // Start edge to RDY edge, in cycles
    function automatic int unsigned MULT_LAT(input int unsigned w);
        return w / 2 + 1;
    endfunction

    function automatic int unsigned DIV_LAT(input int unsigned w);
        return w + 1;
    endfunction

endpackage

// File: rtl/multdiv_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface multdiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic             ctrl_signed;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_result_hi;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, ctrl_signed, data_operandA, data_operandB,
        input  data_result, data_result_hi, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, ctrl_signed, data_operandA, data_operandB,
        output data_result, data_result_hi, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_addsub.sv
// Shared adder/subtractor; cout_o is the no-borrow flag when subtracting.
module multdiv_addsub #(
    parameter int unsigned WIDTH = 34
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    logic [WIDTH-1:0] b_eff;

    // Two's-complement subtract: invert b and inject carry
    always_comb begin
        b_eff = sub_i ? ~b_i : b_i;
        {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};
    end
endmodule

// File: rtl/multdiv_seq.sv
// Iterative radix-4 Booth multiplier / restoring divider sharing one adder.
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic      clock,
    input logic      reset_n,
    multdiv_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam int unsigned AccW = 2 * WIDTH + 3;
    localparam int unsigned AddW = WIDTH + 2;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic             sgn_q, sgn_d;
    logic             corr_q, corr_d;    // unsigned multiply with multiplier MSB set
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;      // signed MIN / -1
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [AddW-1:0]  m_q, m_d;          // multiplicand or divisor magnitude
    logic [AccW-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             exc_q, exc_d;

    logic [AddW-1:0]  add_a, add_b, add_sum;
    logic             add_sub, add_cout;
    booth_e           booth;
    logic [WIDTH-1:0] a_mag, b_mag, div_rem, rem_mag;
    logic             div_qbit;

    multdiv_addsub #(.WIDTH(AddW)) u_addsub (
        .a_i    (add_a),
        .b_i    (add_b),
        .sub_i  (add_sub),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    assign booth   = booth_decode(acc_q[2:0]);
    assign rem_mag = acc_q[2*WIDTH-1:WIDTH];

    // Adder operand steering per state
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        case (state_q)
            MULT: begin
                add_a = acc_q[AccW-1:WIDTH+1];
                case (booth)
                    BoothP1: add_b = m_q;
                    BoothP2: add_b = {m_q[AddW-2:0], 1'b0};
                    BoothM1: begin add_b = m_q; add_sub = 1'b1; end
                    BoothM2: begin add_b = {m_q[AddW-2:0], 1'b0}; add_sub = 1'b1; end
                    default: add_b = '0;
                endcase
            end
            DIV: begin
                // Trial subtract of divisor from shifted partial remainder
                add_a   = {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
                add_b   = m_q;
                add_sub = 1'b1;
            end
            FIX: begin
                if (op_q == OP_MULT) begin
                    // Booth treats the multiplier as signed; add A<<WIDTH back if unsigned
                    add_a = acc_q[AccW-1:WIDTH+1];
                    add_b = corr_q ? m_q : '0;
                end else begin
                    add_b   = {2'b00, acc_q[WIDTH-1:0]};
                    add_sub = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // FSM next state, operand capture and iteration datapath
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sgn_d    = sgn_q;
        corr_d   = corr_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        m_d      = m_q;
        acc_d    = acc_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        exc_d    = exc_q;
        a_mag    = bus.data_operandA;
        b_mag    = bus.data_operandB;
        div_rem  = '0;
        div_qbit = 1'b0;

        if (bus.ctrl_MULT || bus.ctrl_DIV) begin
            res_d    = '0;
            res_hi_d = '0;
            exc_d    = 1'b0;
            sgn_d    = bus.ctrl_signed;
            corr_d   = 1'b0;
            qneg_d   = 1'b0;
            rneg_d   = 1'b0;
            dz_d     = 1'b0;
            ovf_d    = 1'b0;
            if (bus.ctrl_MULT) begin
                op_d    = OP_MULT;
                state_d = MULT;
                cnt_d   = CntW'(MULT_LAT(WIDTH) - 1);
                m_d     = bus.ctrl_signed ?
                          {{2{bus.data_operandA[WIDTH-1]}}, bus.data_operandA} :
                          {2'b00, bus.data_operandA};
                acc_d   = {{AddW{1'b0}}, bus.data_operandB, 1'b0};
                corr_d  = !bus.ctrl_signed && bus.data_operandB[WIDTH-1];
            end else begin
                if (bus.ctrl_signed && bus.data_operandA[WIDTH-1]) begin
                    a_mag = ~bus.data_operandA + WIDTH'(1);
                end
                if (bus.ctrl_signed && bus.data_operandB[WIDTH-1]) begin
                    b_mag = ~bus.data_operandB + WIDTH'(1);
                end
                op_d   = OP_DIV;
                dz_d   = (bus.data_operandB == '0);
                ovf_d  = bus.ctrl_signed && (bus.data_operandB == '1) &&
                         (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}});
                qneg_d = bus.ctrl_signed &&
                         (bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1]);
                rneg_d = bus.ctrl_signed && bus.data_operandA[WIDTH-1];
                cnt_d  = CntW'(DIV_LAT(WIDTH) - 1);
                m_d    = {2'b00, b_mag};
                // Divide-by-zero keeps the raw dividend for the remainder and skips iterating
                acc_d   = {{(WIDTH+3){1'b0}}, dz_d ? bus.data_operandA : a_mag};
                state_d = dz_d ? FIX : DIV;
            end
        end else begin
            case (state_q)
                MULT: begin
                    acc_d = AccW'($signed({add_sum, acc_q[WIDTH:0]}) >>> 2);
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) state_d = FIX;
                end
                DIV: begin
                    if (add_cout) begin
                        div_rem  = add_sum[WIDTH-1:0];
                        div_qbit = 1'b1;
                    end else begin
                        div_rem  = {acc_q[2*WIDTH-2:WIDTH], acc_q[WIDTH-1]};
                    end
                    acc_d = {3'b000, div_rem, acc_q[WIDTH-2:0], div_qbit};
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) state_d = FIX;
                end
                FIX: begin
                    state_d = DONE;
                    if (op_q == OP_MULT) begin
                        res_d    = acc_q[WIDTH:1];
                        res_hi_d = add_sum[WIDTH-1:0];
                        exc_d    = sgn_q ? (add_sum[WIDTH-1:0] != {WIDTH{acc_q[WIDTH]}}) :
                                           (add_sum[WIDTH-1:0] != '0);
                    end else if (dz_q) begin
                        res_d    = '1;
                        res_hi_d = acc_q[WIDTH-1:0];
                        exc_d    = 1'b1;
                    end else begin
                        res_d    = qneg_q ? add_sum[WIDTH-1:0] : acc_q[WIDTH-1:0];
                        res_hi_d = rneg_q ? (~rem_mag + WIDTH'(1)) : rem_mag;
                        exc_d    = ovf_q;
                    end
                end
                DONE:    state_d = IDLE;
                default: ;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= OP_MULT;
            sgn_q    <= 1'b0;
            corr_q   <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sgn_q    <= sgn_d;
            corr_q   <= corr_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            exc_q    <= exc_d;
        end
    end

    assign bus.data_result    = res_q;
    assign bus.data_result_hi = res_hi_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = (state_q == DONE);
    assign bus.busy           = (state_q == MULT) || (state_q == DIV) || (state_q == FIX);

endmodule
